key_loader: RTL and testbench
=============================

Name: key_loader

Overview:
- Serial key-loading stage directly upstream of a locked netlist built from the gate-cell library.
- Accepts a key bit-serially over a valid/ready handshake and checks an even-parity trailer bit.
- On a good load, drives the full parallel key bus into the locked circuit's key inputs.
- Holds the key bus at all-zero (the non-unlocking value) until a load passes the check; enforces a consecutive-failure lockout.

Parameters:
- KEY_WIDTH, 64, number of key bits delivered to the locked netlist (>=2).
- MAX_FAIL, 3, consecutive parity failures before permanent lockout (>=1).

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- clear  in  1  drop the current key or error; honoured in ACTIVE and ERROR only.
- sin_data  in  1  serial key bit, LSB first, followed by one parity bit.
- sin_valid  in  1  sin_data is valid.
- sin_ready  out  1  block accepts a bit; bit transfers when sin_valid && sin_ready.
- key_out  out  KEY_WIDTH  parallel key to the locked netlist; zero unless key_valid.
- key_valid  out  1  key_out holds a checked key.
- busy  out  1  state is LOAD or CHECK.
- err  out  1  last load failed parity (ERROR state).
- lockout  out  1  MAX_FAIL consecutive failures reached; cleared only by RST.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state=IDLE; shift register, bit counter and fail counter cleared.
  - key_out=0; key_valid=0, busy=0, err=0, lockout=0, sin_ready=0.
- States: IDLE, LOAD, CHECK, ACTIVE, ERROR, LOCKOUT.
- IDLE:
  - start=1 -> LOAD next cycle.
  - Bit counter and running parity cleared on entry to LOAD.
- LOAD:
  - sin_ready=1.
  - Accepted bit number i (0..KEY_WIDTH-1) is written to shadow[i]; running parity ^= bit.
  - Accepted bit number KEY_WIDTH is the parity bit: it is XORed into the running parity and the state moves to CHECK next cycle.
  - sin_valid low stalls indefinitely with no timeout.
  - start and clear are ignored.
- CHECK:
  - Lasts exactly one cycle; sin_ready=0.
  - Running parity 0 -> ACTIVE: key_out<=shadow, key_valid=1, fail counter<=0.
  - Running parity 1 -> fail counter+1. If the new count equals MAX_FAIL -> LOCKOUT, else -> ERROR.
  - Latency: parity handshake in cycle N; CHECK in N+1; key_valid/err/lockout visible in N+2.
- ACTIVE:
  - key_out is stable. clear=1 -> IDLE with key_out<=0 and key_valid<=0 on the same edge.
  - start is ignored; a reload requires clear first.
- ERROR:
  - err=1, key_out=0. clear=1 -> IDLE with err<=0; the fail counter is retained.
- LOCKOUT:
  - lockout=1, key_out=0, sin_ready=0. All inputs are ignored until RST.
- Simultaneous start and clear in ACTIVE/ERROR: clear wins, giving IDLE; start is not remembered.
- Reset mid-load discards partial bits; the fail counter is cleared by RST only.
- The shadow register is never visible on key_out except in ACTIVE.
- Bit counter width: $clog2(KEY_WIDTH+1). Fail counter width: $clog2(MAX_FAIL+1); it saturates and never wraps.

Decomposition:
- Shared package key_loader_pkg: state enum (IDLE, LOAD, CHECK, ACTIVE, ERROR, LOCKOUT) and the parity-polarity constant (even).
- One sub-module, key_shift_reg: KEY_WIDTH-bit indexed shadow store plus running-parity accumulator, with load-enable and clear inputs. The FSM and counters stay in key_loader.

Test Plan:
- Reset, then KEY_WIDTH=8: start; send 8'hA5 LSB first (1,0,1,0,0,1,0,1), then parity 0 -> key_valid=1 and key_out=8'hA5 two cycles after the parity handshake; err=0.
- Same key with parity 1 -> err=1, key_out=0, key_valid=0; clear -> IDLE and err=0; a retry with correct parity -> ACTIVE with 8'hA5, fail counter reset.
- MAX_FAIL=3: three consecutive bad loads with clear between them -> lockout=1 after the third; start and sin_valid then ignored, sin_ready=0; RST -> lockout=0.
- sin_valid toggled 1,0,0,1,... during LOAD -> only handshaked bits are shifted; the final key matches the sent bits exactly.
- RST asserted after 4 of 8 bits -> IDLE, outputs at reset values; a fresh full load of 8'h3C with parity 0 -> key_out=8'h3C.
- In ACTIVE, start and clear asserted together -> IDLE with key_out=0; no LOAD entered (sin_ready stays 0).

Source files
------------

// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
package key_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StActive,
    StError,
    StLockout
  } state_e;

  // Even parity: XOR of every key bit plus the trailer must come out zero.
  localparam logic PARITY_GOOD = 1'b0;

endpackage

// File: rtl/key_shift_reg.sv
// Indexed shadow store for incoming key bits plus a running-parity accumulator.
module key_shift_reg #(
  parameter int unsigned KEY_WIDTH = 64,
  parameter int unsigned IDX_W     = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     idx,
  input  logic                 din,
  output logic [KEY_WIDTH-1:0] shadow,
  output logic                 parity
);

  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic                 parity_q, parity_d;

  always_comb begin
    shadow_d = shadow_q;
    parity_d = parity_q;
    if (clr) begin
      shadow_d = '0;
      parity_d = 1'b0;
    end else if (load_en) begin
      parity_d = parity_q ^ din;
      // The trailer bit arrives at idx == KEY_WIDTH and only feeds parity.
      for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
        if (idx == IDX_W'(i)) shadow_d[i] = din;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_q <= '0;
      parity_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      parity_q <= parity_d;
    end
  end

  assign shadow = shadow_q;
  assign parity = parity_q;

endmodule

// File: rtl/key_loader.sv
// Serial key loader: collects a parity-checked key and drives it to the locked netlist.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 64,
  parameter int unsigned MAX_FAIL  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 sin_data,
  input  logic                 sin_valid,
  output logic                 sin_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err,
  output logic                 lockout
);

  localparam int unsigned CW = $clog2(KEY_WIDTH + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FW-1:0]        fail_q, fail_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 sr_clr, sr_en;
  logic [KEY_WIDTH-1:0] shadow;
  logic                 parity;

  key_shift_reg #(
    .KEY_WIDTH(KEY_WIDTH),
    .IDX_W    (CW)
  ) u_shift (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (sr_clr),
    .load_en(sr_en),
    .idx    (cnt_q),
    .din    (sin_data),
    .shadow (shadow),
    .parity (parity)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    key_d   = key_q;
    sr_clr  = 1'b0;
    sr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end
      end
      StLoad: begin
        if (sin_valid) begin
          sr_en = 1'b1;
          if (cnt_q == CW'(KEY_WIDTH)) state_d = StCheck;
          else                         cnt_d   = cnt_q + CW'(1);
        end
      end
      StCheck: begin
        if (parity == PARITY_GOOD) begin
          state_d = StActive;
          key_d   = shadow;
          fail_d  = '0;
        end else begin
          fail_d  = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
          state_d = (fail_d == FW'(MAX_FAIL)) ? StLockout : StError;
        end
      end
      StActive: begin
        if (clear) begin
          state_d = StIdle;
          key_d   = '0;
        end
      end
      StError: begin
        if (clear) state_d = StIdle;
      end
      StLockout: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fail_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      key_q   <= key_d;
    end
  end

  // key_q is only ever non-zero while ACTIVE, so it can drive the bus directly.
  assign key_out   = key_q;
  assign key_valid = (state_q == StActive);
  assign busy      = (state_q == StLoad) || (state_q == StCheck);
  assign err       = (state_q == StError);
  assign lockout   = (state_q == StLockout);
  assign sin_ready = (state_q == StLoad);

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader with a queue-based reference model.
module tb_key_loader;

  localparam int KW = 8;
  localparam int MF = 3;

  localparam int M_IDLE = 0, M_LOAD = 1, M_CHECK = 2, M_ACTIVE = 3, M_ERROR = 4, M_LOCK = 5;

  logic          CLK = 1'b0;
  logic          RST, start, clear, sin_data, sin_valid;
  logic          sin_ready, key_valid, busy, err, lockout;
  logic [KW-1:0] key_out;

  int vectors = 0;
  int fails   = 0;

  key_loader #(
    .KEY_WIDTH(KW),
    .MAX_FAIL (MF)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .clear    (clear),
    .sin_data (sin_data),
    .sin_valid(sin_valid),
    .sin_ready(sin_ready),
    .key_out  (key_out),
    .key_valid(key_valid),
    .busy     (busy),
    .err      (err),
    .lockout  (lockout)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of accepted bits, judged once the trailer arrives.
  int            m_mode = M_IDLE;
  int            m_fails = 0;
  bit            m_live = 1'b0;
  bit            m_q[$];
  logic [KW-1:0] m_key = '0;

  always @(posedge CLK) begin
    if (RST) begin
      m_live = 1'b1;
      m_mode = M_IDLE;
      m_fails = 0;
      m_key = '0;
      m_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_LOAD; m_q.delete(); end
        M_LOAD: if (sin_valid) begin
          m_q.push_back(sin_data);
          if (m_q.size() == KW + 1) m_mode = M_CHECK;
        end
        M_CHECK: begin
          int ones;
          ones = 0;
          foreach (m_q[i]) ones += int'(m_q[i]);
          if (ones % 2 == 0) begin
            for (int i = 0; i < KW; i++) m_key[i] = m_q[i];
            m_fails = 0;
            m_mode = M_ACTIVE;
          end else begin
            m_fails++;
            m_mode = (m_fails == MF) ? M_LOCK : M_ERROR;
          end
        end
        M_ACTIVE: if (clear) begin m_mode = M_IDLE; m_key = '0; end
        M_ERROR:  if (clear) m_mode = M_IDLE;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (m_live) begin
      chk("key_out",   64'(key_out),   64'((m_mode == M_ACTIVE) ? m_key : '0));
      chk("key_valid", 64'(key_valid), 64'(m_mode == M_ACTIVE));
      chk("busy",      64'(busy),      64'(m_mode == M_LOAD || m_mode == M_CHECK));
      chk("err",       64'(err),       64'(m_mode == M_ERROR));
      chk("lockout",   64'(lockout),   64'(m_mode == M_LOCK));
      chk("sin_ready", 64'(sin_ready), 64'(m_mode == M_LOAD));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic send_bit(input logic b);
    bit ok;
    ok = 1'b0;
    sin_data  = b;
    sin_valid = 1'b1;
    for (int g = 0; g < 8 && !ok; g++) begin
      ok = sin_ready;
      tick();
    end
    sin_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_key(input logic [KW-1:0] k, input logic par, input bit gaps);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < KW; i++) begin
      send_bit(k[i]);
      if (gaps) begin tick(); tick(); end
    end
    send_bit(par);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; clear = 1'b0; sin_data = 1'b0; sin_valid = 1'b0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_key_out", 64'(key_out), 64'h0);
    chk("rst_ready",   64'(sin_ready), 64'h0);
    chk("rst_lockout", 64'(lockout), 64'h0);

    // Good load: result must appear exactly two cycles after the trailer handshake.
    load_key(8'hA5, 1'b0, 1'b0);
    chk("a5_check_cycle_valid", 64'(key_valid), 64'h0);
    tick();
    chk("a5_valid", 64'(key_valid), 64'h1);
    chk("a5_key",   64'(key_out),   64'hA5);
    chk("a5_model", 64'(m_key),     64'hA5);

    // Bad parity, clear, then a good retry.
    do_clear();
    load_key(8'hA5, 1'b1, 1'b0);
    tick();
    chk("bad_err", 64'(err),     64'h1);
    chk("bad_key", 64'(key_out), 64'h0);
    do_clear();
    chk("bad_cleared", 64'(err), 64'h0);
    load_key(8'hA5, 1'b0, 1'b0);
    tick();
    chk("retry_key", 64'(key_out), 64'hA5);

    // Three consecutive failures lock the block until reset.
    do_clear();
    for (int n = 0; n < MF; n++) begin
      load_key(8'hA5, 1'b1, 1'b0);
      tick();
      if (n < MF - 1) do_clear();
    end
    chk("locked", 64'(lockout), 64'h1);
    start = 1'b1; sin_valid = 1'b1; clear = 1'b1;
    tick(); tick(); tick();
    chk("locked_ready", 64'(sin_ready), 64'h0);
    chk("locked_stays", 64'(lockout),   64'h1);
    start = 1'b0; sin_valid = 1'b0; clear = 1'b0;
    do_reset();
    chk("unlocked", 64'(lockout), 64'h0);

    // Gapped valid pattern: 8'h5B has five ones, so the trailer is 1.
    load_key(8'h5B, 1'b1, 1'b1);
    tick();
    chk("gap_key", 64'(key_out), 64'h5B);

    // Reset mid-load, then a fresh load.
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_reset();
    chk("midrst_busy",  64'(busy),      64'h0);
    chk("midrst_ready", 64'(sin_ready), 64'h0);
    load_key(8'h3C, 1'b0, 1'b0);
    tick();
    chk("3c_key", 64'(key_out), 64'h3C);

    // start and clear together in ACTIVE: clear wins, no load begins.
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("both_key", 64'(key_out), 64'h0);
    tick(); tick();
    chk("both_ready", 64'(sin_ready), 64'h0);
    chk("both_busy",  64'(busy),      64'h0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
